// File: rtl/seg7_count_display.sv
// seg7_count_display
//   Shows a 6-bit binary count (0..63) as two decimal digits on a multiplexed,
//   common-anode 7-segment display. A load strobe captures the value. A
//   sequential double-dabble FSM converts it to BCD, and a refresh divider
//   alternates the two digit drivers. All display outputs are active-low.
//
// Parameters
//   REFRESH_DIV : clk_in cycles per digit slot (>= 2)
//   BLANK_LZ    : 1 = blank the tens digit while tens == 0
//
// Ports
//   clk_in  in   system clock, all registers on the rising edge
//   rst     in   synchronous reset, active-low
//   value   in   [5:0] binary count to display
//   load    in   single-cycle capture strobe for value
//   busy    out  high while a conversion is in progress
//   done    out  one-cycle pulse when new digits are committed
//   seg_n   out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dig_n   out  [1:0] digit enables {tens,ones}, active-low
module seg7_count_display #(
  parameter int REFRESH_DIV = 27000,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [5:0] value,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg_n,
  output logic [1:0] dig_n
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    sh_q, sh_d;
  logic [7:0]    bcd_q, bcd_d;
  logic [7:0]    adj;
  logic [2:0]    bit_q, bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [CW-1:0] scan_q, scan_d;
  logic          act_q, act_d;     // 0 = ones slot, 1 = tens slot
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    digit;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM: next state and datapath.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    tens_d  = tens_q;
    ones_d  = ones_q;

    // Add-3 correction applied before each shift. The tens nibble only ever
    // holds 0..3 before the last shift, so it cannot overflow.
    adj = bcd_q;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;

    case (state_q)
      IDLE: begin
        if (load) begin
          sh_d    = value;
          bcd_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj[6:0], sh_q, 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd5) state_d = COMMIT;
      end
      COMMIT: begin
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy stays high through the cycle in which done is asserted, so it
    // drops one cycle after the COMMIT edge.
    busy_d = (state_d != IDLE) || (state_q == COMMIT);
    done_d = (state_q == COMMIT);
  end

  // Refresh divider and registered display outputs. The divider free-runs
  // independently of the conversion.
  always_comb begin
    scan_d = scan_q;
    act_d  = act_q;
    if (scan_q == CW'(REFRESH_DIV - 1)) begin
      scan_d = '0;
      act_d  = ~act_q;
    end else begin
      scan_d = scan_q + CW'(1);
    end

    digit = act_q ? tens_q : ones_q;
    seg_d = dec7(digit);
    if ((BLANK_LZ != 0) && act_q && (tens_q == 4'd0)) seg_d = 7'b1111111;
    dig_d = act_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tens_q  <= '0;
      ones_q  <= '0;
      scan_q  <= '0;
      act_q   <= 1'b0;
      seg_q   <= 7'b1111111;
      dig_q   <= 2'b11;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      scan_q  <= scan_d;
      act_q   <= act_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign seg_n = seg_q;
  assign dig_n = dig_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// Testbench for seg7_count_display: table of values with hand-computed
// segment patterns, plus directed multi-cycle sequences (reset, ignored
// loads, load right after commit, glitch-free hold, reset mid-conversion).
module tb_seg7_count_display;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b0;
  logic       load   = 1'b0;
  logic [5:0] value  = 6'd0;
  logic       busy, done, busy2, done2;
  logic [6:0] seg_n, seg2;
  logic [1:0] dig_n, dig2;

  seg7_count_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .clk_in(clk_in), .rst(rst), .value(value), .load(load),
    .busy(busy), .done(done), .seg_n(seg_n), .dig_n(dig_n));

  seg7_count_display #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk_in(clk_in), .rst(rst), .value(value), .load(load),
    .busy(busy2), .done(done2), .seg_n(seg2), .dig_n(dig2));

  always #5 clk_in = ~clk_in;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int done_cnt = 0;

  always @(negedge clk_in) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [5:0] v;
    logic [6:0] st;   // tens slot, blanking on
    logic [6:0] so;   // ones slot
    logic [6:0] st0;  // tens slot, blanking off
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Returns just after the load edge N.
  task automatic load_val(input logic [5:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic observe(input string nm, input logic [6:0] et, input logic [6:0] eo,
                         input logic [6:0] et0);
    logic [6:0] gt, go, gt0;
    int bad;
    gt = 7'bx; go = 7'bx; gt0 = 7'bx; bad = 0;
    repeat (10) begin
      step();
      if (dig_n == 2'b10) go = seg_n;
      else if (dig_n == 2'b01) gt = seg_n;
      else bad++;
      if (dig2 == 2'b01) gt0 = seg2;
    end
    chk({nm, " tens"}, gt, et);
    chk({nm, " ones"}, go, eo);
    chk({nm, " tens_noblank"}, gt0, et0);
    chk({nm, " dig_valid"}, bad, 0);
  endtask

  initial begin
    int lat, base, bad;
    tbl[0] = '{6'd45, 7'b0011001, 7'b0010010, 7'b0011001};
    tbl[1] = '{6'd63, 7'b0000010, 7'b0110000, 7'b0000010};
    tbl[2] = '{6'd0,  7'b1111111, 7'b1000000, 7'b1000000};
    tbl[3] = '{6'd9,  7'b1111111, 7'b0010000, 7'b1000000};
    tbl[4] = '{6'd27, 7'b0100100, 7'b1111000, 7'b0100100};
    tbl[5] = '{6'd12, 7'b1111001, 7'b0100100, 7'b1111001};
    tbl[6] = '{6'd60, 7'b0000010, 7'b1000000, 7'b0000010};
    tbl[7] = '{6'd38, 7'b0110000, 7'b0000000, 7'b0110000};

    // Reset state and first cycles after release.
    step(); step();
    chk("rst seg", seg_n, 7'b1111111);
    chk("rst dig", dig_n, 2'b11);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst busy2", busy2, 0);
    chk("rst done2", done2, 0);
    rst = 1'b1;
    step();
    chk("rel dig", dig_n, 2'b10);
    chk("rel seg", seg_n, 7'b1000000);
    repeat (4) step();
    chk("rel+4 dig", dig_n, 2'b01);
    chk("rel+4 seg", seg_n, 7'b1111111);
    chk("rel+4 seg noblank", seg2, 7'b1000000);

    // Table-driven conversions.
    for (int i = 0; i < 8; i++) begin
      base = done_cnt;
      load_val(tbl[i].v);
      chk($sformatf("v%0d busy N", tbl[i].v), busy, 1);
      wait_done(lat);
      chk($sformatf("v%0d latency", tbl[i].v), lat, 7);
      chk($sformatf("v%0d busy N+7", tbl[i].v), busy, 1);
      step();
      chk($sformatf("v%0d busy N+8", tbl[i].v), busy, 0);
      chk($sformatf("v%0d done N+8", tbl[i].v), done, 0);
      observe($sformatf("v%0d", tbl[i].v), tbl[i].st, tbl[i].so, tbl[i].st0);
      chk($sformatf("v%0d done pulses", tbl[i].v), done_cnt - base, 1);
    end

    // Loads while busy and in the COMMIT cycle are ignored.
    base = done_cnt;
    load_val(6'd9);            // after N
    step(); step();            // after N+2
    load_val(6'd50);           // sampled at N+3
    step(); step(); step();    // after N+6
    load_val(6'd50);           // sampled at N+7 (COMMIT)
    chk("ign done N+7", done, 1);
    step();
    chk("ign busy N+8", busy, 0);
    observe("ign", 7'b1111111, 7'b0010000, 7'b1000000);
    chk("ign done pulses", done_cnt - base, 1);

    // Load in the cycle after COMMIT is accepted.
    load_val(6'd45);
    repeat (6) step();         // after N+6
    step();                    // after N+7
    chk("acc done N+7", done, 1);
    load_val(6'd12);           // sampled at N+8
    chk("acc busy", busy, 1);
    wait_done(lat);
    chk("acc latency", lat, 7);
    step();
    observe("acc", 7'b1111001, 7'b0100100, 7'b1111001);

    // Display holds 27 throughout a conversion of 12.
    load_val(6'd27);
    wait_done(lat);
    step();
    observe("pre27", 7'b0100100, 7'b1111000, 7'b0100100);
    load_val(6'd12);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (dig_n == 2'b10 && seg_n != 7'b1111000) bad++;
      if (dig_n == 2'b01 && seg_n != 7'b0100100) bad++;
      if (dig_n != 2'b10 && dig_n != 2'b01) bad++;
      if (k < 7) step();
    end
    chk("hold27 bad", bad, 0);
    chk("hold27 done", done, 1);
    step();
    observe("post12", 7'b1111001, 7'b0100100, 7'b1111001);

    // Reset mid-conversion.
    load_val(6'd33);
    step(); step();            // after N+2
    rst = 1'b0;
    step();                    // N+3
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst seg", seg_n, 7'b1111111);
    chk("midrst dig", dig_n, 2'b11);
    rst = 1'b1;
    base = done_cnt;
    step();
    chk("midrst rel dig", dig_n, 2'b10);
    chk("midrst rel seg", seg_n, 7'b1000000);
    repeat (12) step();
    chk("midrst no done", done_cnt - base, 0);
    observe("midrst", 7'b1111111, 7'b1000000, 7'b1000000);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
